modport_fifo: RTL and testbench

MODPORT_FIFO -- requirements
Module: modport_fifo

---
 rtl/modport_fifo_pkg.sv | 14 +
 rtl/modport_fifo_if.sv | 41 ++++
 rtl/modport_fifo_mem.sv | 31 +++
 rtl/modport_fifo.sv | 92 +++++++++
 tb/tb_modport_fifo.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/modport_fifo_pkg.sv
// Shared constants and helpers for the modport_fifo block.
// Holds the default data width / depth and the address-width derivation
// used by the interface, the storage array and the pointer logic.
package modport_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Address bits needed to index DEPTH entries (DEPTH is a power of two).
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/modport_fifo_if.sv
// Handshake/data bundle between a FIFO user (master) and the FIFO (slave).
// Signals: wr_enb/data_in/rd_enb driven by master; data_out/full/empty
// (and count when FIFO_COUNT_EN is defined) driven by the FIFO.
interface modport_fifo_if
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CNT_W = addr_w(DEPTH) + 1;

    logic              wr_enb;
    logic [DATA_W-1:0] data_in;
    logic              rd_enb;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;

`ifdef FIFO_COUNT_EN
    logic [CNT_W-1:0]  count;

    modport master (
        output wr_enb, data_in, rd_enb,
        input  data_out, full, empty, count
    );
    modport slave (
        input  wr_enb, data_in, rd_enb,
        output data_out, full, empty, count
    );
`else
    modport master (
        output wr_enb, data_in, rd_enb,
        input  data_out, full, empty
    );
    modport slave (
        input  wr_enb, data_in, rd_enb,
        output data_out, full, empty
    );
`endif

endinterface

// File: rtl/modport_fifo_mem.sv
// Storage array for modport_fifo: DEPTH x DATA_W, no reset on contents.
// Latency: write lands on the clock edge; read port is combinational.
// Backpressure: none here -- the caller only asserts we when not full.
// Ports: clk, we/wr_addr/wr_data (sync write), rd_addr/rd_data (async read).
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int AW     = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The registered data_out stage lives in the top, giving 1-cycle read latency.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/modport_fifo.sv
// Synchronous FIFO with pointer/flag/data_out logic; storage in modport_fifo_mem.
// Latency: write visible to a read on the next edge; data_out registered (1 cycle).
// Backpressure: writes while full are dropped, reads while empty are ignored.
// Ports: clk, rst (async active-low), bus (modport_fifo_if.slave).
// Option: define FIFO_COUNT_EN to add the registered occupancy output bus.count.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    modport_fifo_if.slave   bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] mem_rd_data;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;

    // Flags depend on registered pointers only.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Acceptance uses the flags as they stand before the edge, so a
    // simultaneous request while empty (or full) only lets the write
    // (or read) through.
    assign wr_acc = bus.wr_enb && !full;
    assign rd_acc = bus.rd_enb && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_out_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                data_out_q <= mem_rd_data;
            end
        end
    end

    modport_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we      (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    assign bus.data_out = data_out_q;
    assign bus.full     = full;
    assign bus.empty    = empty;

`ifdef FIFO_COUNT_EN
    logic [PW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + PTR_ONE;
                2'b01:   count_q <= count_q - PTR_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.count = count_q;
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Directed testbench for modport_fifo (DATA_W=8, DEPTH=16).
// Covers reset, fill/drain, overflow/underflow, simultaneous requests across
// pointer wrap, simultaneous requests at empty/full, and mid-operation reset.
module tb_modport_fifo;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    modport_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

    modport_fifo #(.DATA_W(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string tag, input int exp);
`ifdef FIFO_COUNT_EN
        check(tag, 32'(bus.count), 32'(exp));
`else
        if (exp < 0) $display("bad count argument for %s", tag);
`endif
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b0;
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
        bus.data_in = '0;

        // Reset held for 3 cycles.
        repeat (3) step();
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'h0);
        chk_count("rst_count", 0);
        rst = 1'b1;

        // Fill with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            bus.wr_enb  = 1'b1;
            bus.data_in = 8'(i);
            step();
            if (i == 15) begin
                check("fill15_full", 32'(bus.full), 32'd0);
                chk_count("fill15_count", 15);
            end
        end
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_empty", 32'(bus.empty), 32'd0);

        // Overflow: 0xAA must be dropped.
        bus.data_in = 8'hAA;
        step();
        bus.wr_enb = 1'b0;
        check("ovf_full", 32'(bus.full), 32'd1);
        check("ovf_dout", 32'(bus.data_out), 32'h0);
        chk_count("ovf_count", 16);

        // Drain in order.
        bus.rd_enb = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("drain%0d", i), 32'(bus.data_out), 32'(i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_full", 32'(bus.full), 32'd0);

        // Underflow: reads ignored, data_out holds 0x10.
        repeat (2) step();
        bus.rd_enb = 1'b0;
        check("udf_dout", 32'(bus.data_out), 32'h10);
        check("udf_empty", 32'(bus.empty), 32'd1);
        chk_count("udf_count", 0);

        // 11 words in and out; first word out proves the read pointer held still.
        for (int i = 0; i < 11; i++) begin
            bus.wr_enb  = 1'b1;
            bus.data_in = 8'(8'h21 + i);
            step();
        end
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step();
            check($sformatf("mid%0d", i), 32'(bus.data_out), 32'(8'h21 + i));
        end
        bus.rd_enb = 1'b0;

        // Pointers now at address 11; store 5 so the next writes wrap.
        for (int i = 0; i < 5; i++) begin
            bus.wr_enb  = 1'b1;
            bus.data_in = 8'(8'h30 + i);
            step();
        end
        // Simultaneous read/write for 10 cycles across the wrap.
        bus.rd_enb = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.data_in = 8'(8'h35 + k);
            step();
            check($sformatf("sim%0d", k), 32'(bus.data_out), 32'(8'h30 + k));
            chk_count($sformatf("sim_count%0d", k), 5);
        end
        bus.wr_enb = 1'b0;
        check("sim_empty", 32'(bus.empty), 32'd0);
        check("sim_full", 32'(bus.full), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("tail%0d", i), 32'(bus.data_out), 32'(8'h3A + i));
        end
        check("tail_empty", 32'(bus.empty), 32'd1);

        // Simultaneous while empty: only the write counts.
        bus.wr_enb  = 1'b1;
        bus.data_in = 8'h77;
        step();
        bus.wr_enb = 1'b0;
        check("se_dout", 32'(bus.data_out), 32'h3E);
        check("se_empty", 32'(bus.empty), 32'd0);
        chk_count("se_count", 1);
        step();
        bus.rd_enb = 1'b0;
        check("se_read", 32'(bus.data_out), 32'h77);
        check("se_empty2", 32'(bus.empty), 32'd1);

        // Simultaneous while full: only the read counts.
        for (int i = 0; i < 16; i++) begin
            bus.wr_enb  = 1'b1;
            bus.data_in = 8'(8'h80 + i);
            step();
        end
        check("sf_pre_full", 32'(bus.full), 32'd1);
        bus.rd_enb  = 1'b1;
        bus.data_in = 8'h99;
        step();
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        check("sf_dout", 32'(bus.data_out), 32'h80);
        check("sf_full", 32'(bus.full), 32'd0);
        chk_count("sf_count", 15);

        // Clean restart, then 8 in, 1 out -> 7 stored, data_out = 0x60.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_enb  = 1'b1;
            bus.data_in = 8'(8'h60 + i);
            step();
        end
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b1;
        step();
        bus.rd_enb = 1'b0;
        check("pre_rst_dout", 32'(bus.data_out), 32'h60);
        chk_count("pre_rst_count", 7);

        // Reset pulse between edges takes effect without a clock.
        #1;
        rst = 1'b0;
        #1;
        check("arst_empty", 32'(bus.empty), 32'd1);
        check("arst_full", 32'(bus.full), 32'd0);
        check("arst_dout", 32'(bus.data_out), 32'h0);
        chk_count("arst_count", 0);
        rst = 1'b1;

        bus.wr_enb  = 1'b1;
        bus.data_in = 8'h55;
        step();
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b1;
        step();
        bus.rd_enb = 1'b0;
        check("post_rst_dout", 32'(bus.data_out), 32'h55);
        check("post_rst_empty", 32'(bus.empty), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
